// File: rtl/alu_arb_pkg.sv
// Purpose: shared types and widths for the round-robin ALU request arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_arb_pkg;

   localparam int RES_W  = 5;   // signed result width
   localparam int OPND_W = 4;   // signed operand width

   typedef enum logic [1:0] {
      OP_ADD   = 2'd0,
      OP_SUB   = 2'd1,
      OP_NOT_A = 2'd2,
      OP_OR_B  = 2'd3
   } alu_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

endpackage

// File: rtl/alu_core4.sv
// Purpose: 4-bit signed ALU (add, sub, not-A, or-reduce-B) producing a 5-bit signed result.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller registers the result.
// Ports: opcode (alu_op_e encoding), a/b (signed 4-bit operands), result (signed 5-bit).
module alu_core4
   import alu_arb_pkg::*;
(
   input  logic [1:0]        opcode,
   input  logic [OPND_W-1:0] a,
   input  logic [OPND_W-1:0] b,
   output logic [RES_W-1:0]  result
);

   logic [RES_W-1:0] a_x;
   logic [RES_W-1:0] b_x;

   // Sign-extend once; a 5-bit result holds every add/sub outcome (-16..15).
   assign a_x = {a[OPND_W-1], a};
   assign b_x = {b[OPND_W-1], b};

   always_comb begin
      result = '0;
      case (alu_op_e'(opcode))
         OP_ADD:   result = a_x + b_x;
         OP_SUB:   result = a_x - b_x;
         OP_NOT_A: result = ~a_x;   // inverting the extended value equals extending ~A
         OP_OR_B:  result = {{(RES_W-1){1'b0}}, |b};
         default:  result = '0;
      endcase
   end

endmodule

// File: rtl/alu_req_arbiter.sv
// Purpose: round-robin scheduler sharing one 4-bit signed ALU between NUM_REQ requesters.
// Latency: accept in cycle N -> rsp_valid from cycle N+2; accepts spaced at least 3 cycles.
// Backpressure: rsp_ready low holds the response; no request is accepted until the handshake.
// Ports: clk/reset_n; req_valid/req_ready/req_opcode/req_a/req_b (packed per requester);
//        rsp_valid/rsp_ready/rsp_data/rsp_id; busy (state != IDLE); ops_done (wrapping count).
module alu_req_arbiter
   import alu_arb_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
   parameter int CNT_W   = 16
)(
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [NUM_REQ-1:0]     req_valid,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic [2*NUM_REQ-1:0]   req_opcode,
   input  logic [4*NUM_REQ-1:0]   req_a,
   input  logic [4*NUM_REQ-1:0]   req_b,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [RES_W-1:0]       rsp_data,
   output logic [ID_W-1:0]        rsp_id,
   output logic                   busy,
   output logic [CNT_W-1:0]       ops_done
);

   state_e             state_q;
   state_e             state_d;
   logic [ID_W-1:0]    last_grant_q;
   logic [ID_W-1:0]    id_q;
   logic [1:0]         op_q;
   logic [OPND_W-1:0]  a_q;
   logic [OPND_W-1:0]  b_q;

   logic               grant_vld;
   logic [ID_W-1:0]    winner;
   logic [1:0]         sel_op;
   logic [OPND_W-1:0]  sel_a;
   logic [OPND_W-1:0]  sel_b;
   logic [RES_W-1:0]   alu_res;
   logic               accept;

   // Rotating-priority search. Offsets are scanned from farthest to nearest so the
   // last hit is the first valid requester above last_grant (modulo NUM_REQ).
   always_comb begin
      int idx;
      idx       = 0;
      grant_vld = 1'b0;
      winner    = last_grant_q;
      sel_op    = '0;
      sel_a     = '0;
      sel_b     = '0;
      for (int off = NUM_REQ; off >= 1; off--) begin
         idx = int'(last_grant_q) + off;
         if (idx >= NUM_REQ) begin
            idx = idx - NUM_REQ;
         end
         if (req_valid[idx]) begin
            grant_vld = 1'b1;
            winner    = ID_W'(idx);
            sel_op    = req_opcode[2*idx +: 2];
            sel_a     = req_a[OPND_W*idx +: OPND_W];
            sel_b     = req_b[OPND_W*idx +: OPND_W];
         end
      end
   end

   assign accept = (state_q == IDLE) && grant_vld;

   always_comb begin
      req_ready = '0;
      if (accept) begin
         req_ready[winner] = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (grant_vld) state_d = EXEC;
         EXEC:    state_d = RESP;
         RESP:    if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   alu_core4 u_alu (
      .opcode (op_q),
      .a      (a_q),
      .b      (b_q),
      .result (alu_res)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_grant_q <= ID_W'(NUM_REQ - 1);   // requester 0 wins first after reset
         id_q         <= '0;
         op_q         <= '0;
         a_q          <= '0;
         b_q          <= '0;
         rsp_valid    <= 1'b0;
         rsp_data     <= '0;
         rsp_id       <= '0;
         ops_done     <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (grant_vld) begin
                  last_grant_q <= winner;
                  id_q         <= winner;
                  op_q         <= sel_op;
                  a_q          <= sel_a;
                  b_q          <= sel_b;
               end
            end
            EXEC: begin
               rsp_data  <= alu_res;
               rsp_id    <= id_q;
               rsp_valid <= 1'b1;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  ops_done  <= ops_done + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Purpose: directed and randomized self-checking bench for alu_req_arbiter (NUM_REQ=2).
// Latency: checks accept -> response spacing of two cycles and three-cycle accept spacing.
// Backpressure: exercises held responses with rsp_ready low and a 4-bit counter twin for wrap.
module tb_alu_req_arbiter;

   localparam int N = 2;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [3:0]  req_opcode;
   logic [7:0]  req_a;
   logic [7:0]  req_b;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [4:0]  rsp_data;
   logic [0:0]  rsp_id;
   logic        busy;
   logic [15:0] ops_done;

   // Twin with a 4-bit counter, fed identical stimulus, so counter wrap is reachable quickly.
   logic [1:0]  req_ready_s;
   logic        rsp_valid_s;
   logic [4:0]  rsp_data_s;
   logic [0:0]  rsp_id_s;
   logic        busy_s;
   logic [3:0]  ops_done_s;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_ops  = 0;

   always #5 clk = ~clk;

   alu_req_arbiter #(.NUM_REQ(N), .CNT_W(16)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_opcode (req_opcode),
      .req_a      (req_a),
      .req_b      (req_b),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .rsp_id     (rsp_id),
      .busy       (busy),
      .ops_done   (ops_done)
   );

   alu_req_arbiter #(.NUM_REQ(N), .CNT_W(4)) dut_s (
      .clk        (clk),
      .reset_n    (reset_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready_s),
      .req_opcode (req_opcode),
      .req_a      (req_a),
      .req_b      (req_b),
      .rsp_valid  (rsp_valid_s),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data_s),
      .rsp_id     (rsp_id_s),
      .busy       (busy_s),
      .ops_done   (ops_done_s)
   );

   // Integer reference model for the ALU.
   function automatic logic [4:0] model(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
      int sa;
      int sb;
      int r;
      sa = a[3] ? int'(a) - 16 : int'(a);
      sb = b[3] ? int'(b) - 16 : int'(b);
      r  = 0;
      case (op)
         2'b00: r = sa + sb;
         2'b01: r = sa - sb;
         2'b10: r = -sa - 1;
         default: r = (b != 4'd0) ? 1 : 0;
      endcase
      return r[4:0];
   endfunction

   task automatic set_req(input int k, input logic v, input logic [1:0] op,
                          input logic [3:0] a, input logic [3:0] b);
      req_valid[k]        = v;
      req_opcode[2*k +: 2] = op;
      req_a[4*k +: 4]      = a;
      req_b[4*k +: 4]      = b;
   endtask

   // Issues one request from requester k and completes its handshake; results unchecked.
   task automatic one_op(input int k, input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
      int cyc;
      bit timeout;
      timeout = 1'b0;
      set_req(k, 1'b1, op, a, b);
      rsp_ready = 1'b1;
      cyc = 0;
      @(negedge clk);
      while (!req_ready[k] && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      if (cyc >= 20) timeout = 1'b1;
      @(posedge clk); #1;
      req_valid[k] = 1'b0;
      cyc = 0;
      @(negedge clk);
      while (!rsp_valid && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      if (cyc >= 20) timeout = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      exp_ops++;
      n_checks++;
      if (timeout) begin
         n_fail++;
         $display("FAIL one_op_timeout: requester %0d got no accept/response within 20 cycles", k);
      end
   endtask

   task automatic test_reset();
      #3;
      n_checks++;
      if (req_ready !== 2'b00 || rsp_valid !== 1'b0 || rsp_data !== 5'd0 || rsp_id !== 1'b0 ||
          busy !== 1'b0 || ops_done !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_state: rdy=%b vld=%b dat=%h id=%h busy=%b ops=%h, need all zero",
                  req_ready, rsp_valid, rsp_data, rsp_id, busy, ops_done);
      end
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (req_ready !== 2'b00 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_no_req: rdy=%b busy=%b, need 00/0", req_ready, busy);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_round_robin();
      int grants;
      int rsps;
      bit drop;
      int exp_order[4];
      logic [4:0] exp_dat[2];
      exp_order  = '{0, 1, 0, 1};
      exp_dat[0] = 5'd5;        // 3 + 2
      exp_dat[1] = 5'b11110;    // 3 - 5 = -2
      grants = 0;
      rsps   = 0;
      drop   = 1'b0;
      set_req(0, 1'b1, 2'b00, 4'd3, 4'd2);
      set_req(1, 1'b1, 2'b01, 4'd3, 4'd5);
      rsp_ready = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (req_ready != 2'b00) begin
            n_checks++;
            if (grants >= 4 || busy !== 1'b0 || req_ready !== 2'(1 << exp_order[grants])) begin
               n_fail++;
               $display("FAIL rr_grant: grant#%0d rdy=%b busy=%b", grants, req_ready, busy);
            end
            grants++;
            if (grants == 4) drop = 1'b1;
         end
         if (rsp_valid && rsp_ready) begin
            n_checks++;
            if (rsps >= 4 || rsp_id !== 1'(exp_order[rsps]) || rsp_data !== exp_dat[exp_order[rsps]]) begin
               n_fail++;
               $display("FAIL rr_resp: rsp#%0d id=%0d dat=%h", rsps, rsp_id, rsp_data);
            end
            rsps++;
            exp_ops++;
         end
         @(posedge clk); #1;
         if (drop) req_valid = 2'b00;
      end
      rsp_ready = 1'b0;
      n_checks++;
      if (grants != 4 || rsps != 4) begin
         n_fail++;
         $display("FAIL rr_count: grants=%0d rsps=%0d, need 4/4", grants, rsps);
      end
   endtask

   task automatic test_arith();
      logic [1:0] t_op[6];
      logic [3:0] t_a[6];
      logic [3:0] t_b[6];
      logic [4:0] t_exp[6];
      t_op  = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b11, 2'b11};
      t_a   = '{4'd7, 4'b1000, 4'd7, 4'b0101, 4'd3, 4'd3};
      t_b   = '{4'd7, 4'd7, 4'b1000, 4'd0, 4'd0, 4'b1000};
      t_exp = '{5'b01110, 5'b10001, 5'b01111, 5'b11010, 5'b00000, 5'b00001};
      for (int i = 0; i < 6; i++) begin
         set_req(0, 1'b1, t_op[i], t_a[i], t_b[i]);
         @(negedge clk);
         n_checks++;
         if (req_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL arith_accept[%0d]: rdy=%b, need 01", i, req_ready);
         end
         @(posedge clk); #1;
         req_valid = 2'b00;
         @(negedge clk);
         n_checks++;
         if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL arith_exec[%0d]: vld=%b busy=%b, need 0/1", i, rsp_valid, busy);
         end
         @(negedge clk);
         n_checks++;
         if (rsp_valid !== 1'b1 || rsp_data !== t_exp[i] || rsp_id !== 1'b0) begin
            n_fail++;
            $display("FAIL arith_result[%0d]: vld=%b dat=%b id=%0d, need 1 %b 0",
                     i, rsp_valid, rsp_data, rsp_id, t_exp[i]);
         end
         rsp_ready = 1'b1;
         @(posedge clk); #1;
         rsp_ready = 1'b0;
         exp_ops++;
         @(negedge clk);
         n_checks++;
         if (ops_done !== 16'(exp_ops) || rsp_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL arith_done[%0d]: ops=%0d vld=%b busy=%b, need ops=%0d", i,
                     ops_done, rsp_valid, busy, exp_ops);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_backpressure();
      set_req(1, 1'b1, 2'b10, 4'd0, 4'd0);   // NotA of 0 -> -1
      rsp_ready = 1'b0;
      @(negedge clk);
      n_checks++;
      if (req_ready !== 2'b10) begin
         n_fail++;
         $display("FAIL bp_accept: rdy=%b, need 10", req_ready);
      end
      @(posedge clk); #1;
      set_req(0, 1'b1, 2'b00, 4'd1, 4'd1);   // both keep requesting through RESP
      @(negedge clk);
      n_checks++;
      if (req_ready !== 2'b00) begin
         n_fail++;
         $display("FAIL bp_exec_ready: rdy=%b, need 00", req_ready);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_checks++;
         if (rsp_valid !== 1'b1 || rsp_data !== 5'b11111 || rsp_id !== 1'b1 ||
             req_ready !== 2'b00 || ops_done !== 16'(exp_ops)) begin
            n_fail++;
            $display("FAIL bp_hold[%0d]: vld=%b dat=%b id=%0d rdy=%b ops=%0d", i,
                     rsp_valid, rsp_data, rsp_id, req_ready, ops_done);
         end
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (req_ready !== 2'b00 || rsp_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_handshake_cycle: rdy=%b vld=%b, need 00/1", req_ready, rsp_valid);
      end
      @(posedge clk); #1;
      req_valid = 2'b00;
      rsp_ready = 1'b0;
      exp_ops++;
      @(negedge clk);
      n_checks++;
      if (ops_done !== 16'(exp_ops) || rsp_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_release: ops=%0d vld=%b busy=%b, need ops=%0d", ops_done, rsp_valid, busy, exp_ops);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_wrap();
      // 11 operations so far; five more bring the 4-bit twin from 11 through 15 to 0.
      for (int i = 0; i < 4; i++) one_op(0, 2'b11, 4'd0, 4'd1);
      n_checks++;
      if (ops_done_s !== 4'd15) begin
         n_fail++;
         $display("FAIL wrap_pre: ops_s=%0d, need 15", ops_done_s);
      end
      one_op(0, 2'b11, 4'd0, 4'd1);
      n_checks++;
      if (ops_done_s !== 4'd0 || ops_done !== 16'd16) begin
         n_fail++;
         $display("FAIL wrap: ops_s=%0d ops=%0d, need 0/16", ops_done_s, ops_done);
      end
   endtask

   task automatic test_async_reset();
      // Reset during EXEC.
      set_req(0, 1'b1, 2'b00, 4'd1, 4'd1);
      rsp_ready = 1'b0;
      @(negedge clk);
      @(posedge clk); #1;
      req_valid = 2'b00;
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      n_checks++;
      if (busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_data !== 5'd0 || rsp_id !== 1'b0 ||
          ops_done !== 16'd0 || ops_done_s !== 4'd0 || req_ready !== 2'b00) begin
         n_fail++;
         $display("FAIL areset_exec: busy=%b vld=%b dat=%h id=%0d ops=%0d ops_s=%0d",
                  busy, rsp_valid, rsp_data, rsp_id, ops_done, ops_done_s);
      end
      @(negedge clk);
      reset_n = 1'b1;
      // Reset during RESP, after requester 1 has been granted.
      @(posedge clk); #1;
      set_req(1, 1'b1, 2'b00, 4'd2, 4'd3);
      @(negedge clk);
      n_checks++;
      if (req_ready !== 2'b10) begin
         n_fail++;
         $display("FAIL areset_req1_accept: rdy=%b, need 10", req_ready);
      end
      @(posedge clk); #1;
      req_valid = 2'b00;
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 5'd5) begin
         n_fail++;
         $display("FAIL areset_resp_reached: vld=%b dat=%0d, need 1/5", rsp_valid, rsp_data);
      end
      reset_n = 1'b0;
      #1;
      n_checks++;
      if (busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_data !== 5'd0 || rsp_id !== 1'b0 || ops_done !== 16'd0) begin
         n_fail++;
         $display("FAIL areset_resp: busy=%b vld=%b dat=%h id=%0d ops=%0d",
                  busy, rsp_valid, rsp_data, rsp_id, ops_done);
      end
      exp_ops = 0;
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;
      set_req(0, 1'b1, 2'b00, 4'd2, 4'd2);
      set_req(1, 1'b1, 2'b00, 4'd5, 4'd5);
      @(negedge clk);
      n_checks++;
      if (req_ready !== 2'b01 || rsp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL areset_priority: rdy=%b vld=%b, need 01/0", req_ready, rsp_valid);
      end
      @(posedge clk); #1;
      req_valid = 2'b00;
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL areset_stale: vld=%b, need 0", rsp_valid);
      end
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 5'd4 || rsp_id !== 1'b0) begin
         n_fail++;
         $display("FAIL areset_first_resp: vld=%b dat=%0d id=%0d, need 1/4/0", rsp_valid, rsp_data, rsp_id);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      exp_ops++;
      @(negedge clk);
      n_checks++;
      if (ops_done !== 16'd1) begin
         n_fail++;
         $display("FAIL areset_ops: ops=%0d, need 1", ops_done);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      int txns;
      int cyc;
      int waits[2];
      logic [5:0] sb[$];
      logic [5:0] got;
      logic [1:0] acc;
      txns  = 0;
      cyc   = 0;
      waits = '{0, 0};
      req_valid = 2'b00;
      rsp_ready = 1'b0;
      while (txns < 10000 && cyc < 60000) begin
         @(negedge clk);
         cyc++;
         acc = 2'b00;
         if (req_ready != 2'b00) begin
            n_checks++;
            if (busy !== 1'b0 || $countones(req_ready) != 1 || (req_ready & ~req_valid) != 2'b00) begin
               n_fail++;
               $display("FAIL rnd_grant_legal: rdy=%b vld=%b busy=%b", req_ready, req_valid, busy);
            end
            for (int k = 0; k < N; k++) begin
               if (req_ready[k]) begin
                  sb.push_back({1'(k), model(req_opcode[2*k +: 2], req_a[4*k +: 4], req_b[4*k +: 4])});
                  acc[k]   = 1'b1;
                  waits[k] = 0;
               end
            end
            for (int k = 0; k < N; k++) begin
               if (!acc[k] && req_valid[k]) begin
                  waits[k]++;
                  n_checks++;
                  if (waits[k] > N - 1) begin
                     n_fail++;
                     $display("FAIL rnd_fairness: requester %0d passed over %0d times", k, waits[k]);
                  end
               end
            end
         end
         if (rsp_valid && rsp_ready) begin
            n_checks++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL rnd_unexpected_resp: id=%0d dat=%h", rsp_id, rsp_data);
            end else begin
               got = sb.pop_front();
               if ({rsp_id, rsp_data} !== got) begin
                  n_fail++;
                  $display("FAIL rnd_resp[%0d]: got id/dat=%h, need %h", txns, {rsp_id, rsp_data}, got);
               end
            end
            txns++;
            exp_ops++;
         end
         @(posedge clk); #1;
         for (int k = 0; k < N; k++) begin
            if (acc[k]) req_valid[k] = 1'b0;
            if (!req_valid[k] && $urandom_range(0, 3) != 0) begin
               set_req(k, 1'b1, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            end
         end
         rsp_ready = ($urandom_range(0, 7) != 0);
      end
      @(posedge clk); #1;
      req_valid = 2'b00;
      rsp_ready = 1'b0;
      n_checks++;
      if (txns < 10000 || sb.size() != 0) begin
         n_fail++;
         $display("FAIL rnd_completion: txns=%0d pending=%0d, need 10000/0", txns, sb.size());
      end
      @(negedge clk);
      n_checks++;
      if (ops_done !== 16'(exp_ops) || ops_done_s !== 4'(exp_ops)) begin
         n_fail++;
         $display("FAIL rnd_ops: ops=%0d ops_s=%0d, need %0d/%0d", ops_done, ops_done_s,
                  16'(exp_ops), 4'(exp_ops));
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      req_valid  = 2'b00;
      req_opcode = '0;
      req_a      = '0;
      req_b      = '0;
      rsp_ready  = 1'b0;
      test_reset();
      test_round_robin();
      test_arith();
      test_backpressure();
      test_wrap();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
